wshb_arbiter_rr: RTL and testbench
==================================

// Module: wshb_arbiter_rr
// PURPOSE
//  Round-robin arbiter sharing the single Wishbone port of the SDRAM controller
//  between two masters: m0 = VGA framebuffer reader, m1 = framebuffer writer.
//  Owner's bus is muxed to the slave with zero added latency.
//  A per-grant ack budget prevents the streaming VGA reader from starving m1.
// PARAMETERS
//  ADDR_W     32  address width
//  DATA_W     16  data width (one RGB565 pixel)
//  MAX_GRANT  64  acks allowed per grant before forced rotation (>=1)
// PORTS
//  CLK       in   1          system clock (Wishbone clock)
//  NRST      in   1          asynchronous active-low reset
//  m0_cyc    in   1          master 0 cycle / request
//  m0_stb    in   1          master 0 strobe
//  m0_we     in   1          master 0 write enable
//  m0_adr    in   ADDR_W     master 0 byte address
//  m0_sel    in   DATA_W/8   master 0 byte select
//  m0_dat_ms in   DATA_W     master 0 write data
//  m0_ack    out  1          ack routed to master 0
//  m1_*      (same set as m0_*, for master 1)
//  s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_ms  out   muxed request to SDRAM ctrl
//  s_ack     in   1          slave ack
//  s_dat_sm  in   DATA_W     slave read data, fanned out to both masters unmodified
//  grant     out  2          one-hot current owner ({m1,m0}); 00 = none
// BEHAVIOUR
//  - States: IDLE, GNT0, GNT1 (registered); grant = {state==GNT1, state==GNT0}.
//  - Reset (async, NRST=0): state IDLE, last=1 (m0 wins first tie), ack_cnt=0.
//    Outputs forced: s_cyc=s_stb=s_we=0, s_adr=s_sel=s_dat_ms=0, m0_ack=m1_ack=0, grant=00.
//  - IDLE: s_* driven 0. Next edge: only mX_cyc -> GNTX; both -> the master
//    other than `last`; none -> stay IDLE. Grant latency = 1 cycle after cyc.
//  - GNTX: s_* = mX_* combinationally; mX_ack = s_ack; other master ack = 0.
//    ack_cnt increments on each s_ack while in GNTX.
//  - Leave GNTX at clock edge when:
//    a) mX_cyc=0: go GNTY if mY_cyc=1 (no IDLE bubble), else IDLE;
//    b) s_ack=1 and ack_cnt==MAX_GRANT-1 and mY_cyc=1: go GNTY (forced rotation;
//       safe since each classic cycle ends on ack; mX stalls with ack=0).
//    On any exit: last=X, ack_cnt=0.
//  - Budget exhausted with mY_cyc=0: stay GNTX, ack_cnt saturates at MAX_GRANT-1
//    (no wrap); rotation happens on the first ack after mY requests.
//  - s_ack while IDLE (spurious) is ignored; no master ack.
//  - mX_stb without mX_cyc is never forwarded (s_stb = owner cyc & stb).
//  - ack_cnt width = $clog2(MAX_GRANT)+1 (min 1).
//  - Reset mid-transfer: outputs drop to reset values immediately, in-flight
//    transfer abandoned; SDRAM ctrl must tolerate cyc dropping.
// TESTING
//  1. m0 alone, cyc=stb=1, 5 reads, slave acks each after 2 cycles -> grant=01 one
//     cycle after cyc, s_adr=m0_adr, 5 m0_ack pulses, m1_ack stays 0.
//  2. After reset m0,m1 raise cyc same cycle -> GNT0 first; m0 drops cyc -> grant=10
//     on next edge, no cycle with grant=00.
//  3. MAX_GRANT=4, both hold cyc/stb, slave acks every cycle -> grant alternates
//     01/10 every 4 acks; each master receives exactly 4 acks per slot.
//  4. MAX_GRANT=4, m1 alone for 10 acks -> grant stays 10; m0 raises cyc after ack 10
//     -> switch to GNT0 on m1's next ack.
//  5. s_ack pulsed while IDLE -> m0_ack=m1_ack=0, state remains IDLE.
//  6. NRST low during GNT1 with stb pending -> same-cycle s_cyc=0, grant=00;
//     after release with both requesting -> GNT0 first.

Source files
------------

// File: rtl/wshb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone slave port between two classic-cycle masters.
// The owner's request is muxed to the slave with no added latency; an ack budget forces rotation.
module wshb_arbiter_rr #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int MAX_GRANT = 64
) (
  input  logic                CLK,
  input  logic                NRST,
  input  logic                m0_cyc,
  input  logic                m0_stb,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_adr,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [DATA_W-1:0]   m0_dat_ms,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_dat_sm,
  input  logic                m1_cyc,
  input  logic                m1_stb,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_adr,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [DATA_W-1:0]   m1_dat_ms,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_dat_sm,
  output logic                s_cyc,
  output logic                s_stb,
  output logic                s_we,
  output logic [ADDR_W-1:0]   s_adr,
  output logic [DATA_W/8-1:0] s_sel,
  output logic [DATA_W-1:0]   s_dat_ms,
  input  logic                s_ack,
  input  logic [DATA_W-1:0]   s_dat_sm,
  output logic [1:0]          grant
);

  localparam int CNT_W = $clog2(MAX_GRANT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_GRANT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;   // 1: m1 owned last, so m0 wins a tie
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && m1_cyc) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc)      state_d = GNT0;
        else if (m1_cyc)      state_d = GNT1;
      end
      GNT0: begin
        if (!m0_cyc) begin
          state_d = m1_cyc ? GNT1 : IDLE;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (s_ack) begin
          // Budget spent: rotate only if the other master waits, else saturate.
          if (cnt_q == CNT_LAST) begin
            if (m1_cyc) begin
              state_d = GNT1;
              last_d  = 1'b0;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      GNT1: begin
        if (!m1_cyc) begin
          state_d = m0_cyc ? GNT0 : IDLE;
          last_d  = 1'b1;
          cnt_d   = '0;
        end else if (s_ack) begin
          if (cnt_q == CNT_LAST) begin
            if (m0_cyc) begin
              state_d = GNT0;
              last_d  = 1'b1;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Wishbone classic handshake: a beat transfers when s_cyc & s_stb & s_ack are all high
  // on the same edge; the master holds its request stable until it sees its ack.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_sel    = '0;
    s_dat_ms = '0;
    case (state_q)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_cyc & m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_sel    = m0_sel;
        s_dat_ms = m0_dat_ms;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_cyc & m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_sel    = m1_sel;
        s_dat_ms = m1_dat_ms;
      end
      default: ;
    endcase
  end

  assign m0_ack    = (state_q == GNT0) && s_ack;
  assign m1_ack    = (state_q == GNT1) && s_ack;
  assign m0_dat_sm = s_dat_sm;
  assign m1_dat_sm = s_dat_sm;
  assign grant     = {state_q == GNT1, state_q == GNT0};

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Directed bench for wshb_arbiter_rr with MAX_GRANT=4: solo reads, tie-break,
// budget rotation, saturation, spurious ack and reset mid-grant.
module tb_wshb_arbiter_rr;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 16;

  logic                CLK = 1'b0;
  logic                NRST;
  logic                m0_cyc, m0_stb, m0_we;
  logic [ADDR_W-1:0]   m0_adr;
  logic [DATA_W/8-1:0] m0_sel;
  logic [DATA_W-1:0]   m0_dat_ms;
  logic                m0_ack;
  logic [DATA_W-1:0]   m0_dat_sm;
  logic                m1_cyc, m1_stb, m1_we;
  logic [ADDR_W-1:0]   m1_adr;
  logic [DATA_W/8-1:0] m1_sel;
  logic [DATA_W-1:0]   m1_dat_ms;
  logic                m1_ack;
  logic [DATA_W-1:0]   m1_dat_sm;
  logic                s_cyc, s_stb, s_we;
  logic [ADDR_W-1:0]   s_adr;
  logic [DATA_W/8-1:0] s_sel;
  logic [DATA_W-1:0]   s_dat_ms;
  logic                s_ack;
  logic [DATA_W-1:0]   s_dat_sm;
  logic [1:0]          grant;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  wshb_arbiter_rr #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_GRANT(4)) dut (
    .CLK(CLK), .NRST(NRST),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
    .m0_sel(m0_sel), .m0_dat_ms(m0_dat_ms), .m0_ack(m0_ack), .m0_dat_sm(m0_dat_sm),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
    .m1_sel(m1_sel), .m1_dat_ms(m1_dat_ms), .m1_ack(m1_ack), .m1_dat_sm(m1_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_ms(s_dat_ms), .s_ack(s_ack), .s_dat_sm(s_dat_sm), .grant(grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    NRST = 1'b0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat_ms = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat_ms = '0;
    s_ack = 0; s_dat_sm = 16'hBEEF;
    step(); step();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_s_cyc", 32'(s_cyc), 32'h0);
    chk("rst_s_adr", s_adr, 32'h0);
    NRST = 1'b1;
    step();

    // m0 alone, five reads acked two cycles after each request
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_1230; m0_sel = 2'b11;
    m1_adr = 32'h0000_5670; m1_sel = 2'b01; m1_we = 1; m1_dat_ms = 16'hA5A5;
    #1;
    chk("t1_grant_lat", 32'(grant), 32'h0);
    chk("t1_s_cyc_lat", 32'(s_cyc), 32'h0);
    step();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_s_adr", s_adr, 32'h0000_1230);
    chk("t1_s_stb", 32'(s_stb), 32'h1);
    chk("t1_dat_fan", 32'(m0_dat_sm), 32'hBEEF);
    for (int i = 0; i < 5; i++) begin
      step(); step();
      s_ack = 1; #1;
      chk("t1_m0_ack", 32'(m0_ack), 32'h1);
      chk("t1_m1_ack", 32'(m1_ack), 32'h0);
      step();
      s_ack = 0;
    end
    m0_cyc = 0; m0_stb = 0;
    step();
    chk("t1_release", 32'(grant), 32'h0);

    // Reset, then simultaneous requests: m0 first, handover without an idle cycle
    NRST = 0; #1;
    chk("t2_rst_grant", 32'(grant), 32'h0);
    step();
    NRST = 1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();
    chk("t2_first", 32'(grant), 32'h1);
    m0_cyc = 0; m0_stb = 0; #1;
    chk("t2_s_cyc_drop", 32'(s_cyc), 32'h0);
    step();
    chk("t2_handover", 32'(grant), 32'h2);
    chk("t2_s_adr", s_adr, 32'h0000_5670);
    chk("t2_s_we", 32'(s_we), 32'h1);
    chk("t2_s_dat", 32'(s_dat_ms), 32'hA5A5);

    // Both requesting, ack every cycle: four acks per slot, starting in GNT1
    m0_cyc = 1; m0_stb = 1; s_ack = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      exp_g = ((i / 4) % 2 == 0) ? 2'b10 : 2'b01;
      chk("t3_grant", 32'(grant), 32'(exp_g));
      chk("t3_m0_ack", 32'(m0_ack), 32'(exp_g[0]));
      chk("t3_m1_ack", 32'(m1_ack), 32'(exp_g[1]));
      step();
    end

    // m1 alone for ten acks keeps the grant; m0 then takes over on m1's next ack
    #1;
    chk("t4_start", 32'(grant), 32'h2);
    m0_cyc = 0; m0_stb = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_hold", 32'(grant), 32'h2);
      chk("t4_m1_ack", 32'(m1_ack), 32'h1);
      step();
    end
    s_ack = 0; m0_cyc = 1; m0_stb = 1;
    step();
    chk("t4_wait_ack", 32'(grant), 32'h2);
    s_ack = 1; #1;
    chk("t4_last_ack", 32'(m1_ack), 32'h1);
    step();
    s_ack = 0;
    chk("t4_rotate", 32'(grant), 32'h1);

    // Spurious ack while idle
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    step();
    chk("t5_idle", 32'(grant), 32'h0);
    s_ack = 1; #1;
    chk("t5_m0_ack", 32'(m0_ack), 32'h0);
    chk("t5_m1_ack", 32'(m1_ack), 32'h0);
    step();
    chk("t5_stay_idle", 32'(grant), 32'h0);
    s_ack = 0;

    // stb without cyc is never forwarded (still idle, then m0 granted with stb only)
    m1_stb = 1; #1;
    chk("t5_stb_only", 32'(s_stb), 32'h0);
    step();
    chk("t5_stb_no_grant", 32'(grant), 32'h0);

    // Reset asserted during GNT1 with a strobe pending
    m1_cyc = 1;
    step();
    chk("t6_gnt1", 32'(grant), 32'h2);
    chk("t6_s_stb", 32'(s_stb), 32'h1);
    NRST = 0; #1;
    chk("t6_rst_s_cyc", 32'(s_cyc), 32'h0);
    chk("t6_rst_s_stb", 32'(s_stb), 32'h0);
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_s_adr", s_adr, 32'h0);
    step();
    m0_cyc = 1; m0_stb = 1;
    NRST = 1;
    step();
    chk("t6_tie_m0", 32'(grant), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
